// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control unit: FETCH then one or two execute states.
// Emits the 34-bit datapath control word and the extended immediate each cycle.
module legv8_control_unit (
  input  logic        clock,
  input  logic        reset,
  output logic [33:0] ControlWord,
  output logic [63:0] constant,
  input  logic [31:0] instruction,
  input  logic [4:0]  status
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EX0   = 2'b01,
    S_EX1   = 2'b10
  } state_t;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_ADDI, OP_SUBI, OP_ADDIS, OP_SUBIS,
    OP_AND, OP_ORR, OP_EOR, OP_ANDS, OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS,
    OP_LSL, OP_LSR, OP_LDUR, OP_STUR, OP_MOVZ, OP_MOVK,
    OP_CBZ, OP_CBNZ, OP_BCOND, OP_B, OP_BL, OP_BR
  } op_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  state_t      r_state;
  state_t      w_next;
  op_t         w_op;
  logic [4:0]  w_rd, w_rn, w_rm;
  logic [4:0]  w_da, w_sa, w_sb, w_fs;
  logic        w_c0, w_rw, w_mw, w_bsel, w_en_alu, w_en_mem, w_en_pc;
  logic        w_pcsel, w_sl, w_irload;
  logic [1:0]  w_ps, w_ns;
  logic [33:0] w_cw;
  logic [63:0] w_const;

  // Evaluates a B.cond condition code against {V,C,N,Z}.
  function automatic logic f_cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic z, n, c, v, base;
    z = flags[0];
    n = flags[1];
    c = flags[2];
    v = flags[3];
    case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cond[0] && cond != 4'b1111) ? ~base : base;
  endfunction

  assign w_rd = instruction[4:0];
  assign w_rn = instruction[9:5];
  assign w_rm = instruction[20:16];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_op = OP_NOP;
    casez (instruction[31:21])
      11'b10001011000: w_op = OP_ADD;
      11'b11001011000: w_op = OP_SUB;
      11'b10101011000: w_op = OP_ADDS;
      11'b11101011000: w_op = OP_SUBS;
      11'b1001000100?: w_op = OP_ADDI;
      11'b1101000100?: w_op = OP_SUBI;
      11'b1011000100?: w_op = OP_ADDIS;
      11'b1111000100?: w_op = OP_SUBIS;
      11'b10001010000: w_op = OP_AND;
      11'b10101010000: w_op = OP_ORR;
      11'b11001010000: w_op = OP_EOR;
      11'b11101010000: w_op = OP_ANDS;
      11'b1001001000?: w_op = OP_ANDI;
      11'b1011001000?: w_op = OP_ORRI;
      11'b1101001000?: w_op = OP_EORI;
      11'b1111001000?: w_op = OP_ANDIS;
      11'b11010011011: w_op = OP_LSL;
      11'b11010011010: w_op = OP_LSR;
      11'b11111000010: w_op = OP_LDUR;
      11'b11111000000: w_op = OP_STUR;
      11'b110100101??: w_op = OP_MOVZ;
      11'b111100101??: w_op = OP_MOVK;
      11'b10110100???: w_op = OP_CBZ;
      11'b10110101???: w_op = OP_CBNZ;
      11'b01010100???: w_op = OP_BCOND;
      11'b000101?????: w_op = OP_B;
      11'b100101?????: w_op = OP_BL;
      11'b11010110000: w_op = OP_BR;
      default:         w_op = OP_NOP;
    endcase
  end

  always_comb begin
    w_da     = '0;
    w_sa     = '0;
    w_sb     = '0;
    w_fs     = '0;
    w_c0     = 1'b0;
    w_rw     = 1'b0;
    w_mw     = 1'b0;
    w_bsel   = 1'b0;
    w_en_alu = 1'b0;
    w_en_mem = 1'b0;
    w_en_pc  = 1'b0;
    w_ps     = 2'b00;
    w_pcsel  = 1'b0;
    w_sl     = 1'b0;
    w_irload = 1'b0;
    w_ns     = S_FETCH;
    case (r_state)
      S_FETCH: begin
        w_irload = 1'b1;
        w_ps     = 2'b01;
        w_ns     = S_EX0;
      end
      S_EX0: begin
        if (w_op != OP_NOP) begin
          w_da = w_rd;
          w_sa = w_rn;
          w_sb = w_rm;
        end
        case (w_op)
          OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_ADDI, OP_SUBI, OP_ADDIS, OP_SUBIS: begin
            w_fs     = FS_ADD;
            w_en_alu = 1'b1;
            w_rw     = 1'b1;
            w_bsel   = w_op inside {OP_ADDI, OP_SUBI, OP_ADDIS, OP_SUBIS};
            w_sl     = w_op inside {OP_ADDS, OP_SUBS, OP_ADDIS, OP_SUBIS};
            if (w_op inside {OP_SUB, OP_SUBS, OP_SUBI, OP_SUBIS}) begin
              w_fs[1] = 1'b1;
              w_c0    = 1'b1;
            end
          end
          OP_AND, OP_ORR, OP_EOR, OP_ANDS, OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS: begin
            if (w_op inside {OP_ORR, OP_ORRI})      w_fs = FS_OR;
            else if (w_op inside {OP_EOR, OP_EORI}) w_fs = FS_XOR;
            else                                    w_fs = FS_AND;
            w_en_alu = 1'b1;
            w_rw     = 1'b1;
            w_bsel   = w_op inside {OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS};
            w_sl     = w_op inside {OP_ANDS, OP_ANDIS};
          end
          OP_LSL, OP_LSR: begin
            w_fs     = (w_op == OP_LSL) ? FS_LSL : FS_LSR;
            w_bsel   = 1'b1;
            w_en_alu = 1'b1;
            w_rw     = 1'b1;
          end
          OP_LDUR: begin
            w_fs     = FS_ADD;
            w_bsel   = 1'b1;
            w_en_mem = 1'b1;
            w_rw     = 1'b1;
          end
          OP_STUR: begin
            w_fs   = FS_ADD;
            w_bsel = 1'b1;
            w_mw   = 1'b1;
            w_sb   = w_rd;
          end
          OP_MOVZ: begin
            w_sa     = 5'd31;
            w_fs     = FS_OR;
            w_bsel   = 1'b1;
            w_en_alu = 1'b1;
            w_rw     = 1'b1;
          end
          // MOVK clears the target halfword (AND with ~constant) before OR-ing it in.
          OP_MOVK: begin
            w_sa     = w_rd;
            w_fs     = FS_AND | 5'b00010;
            w_bsel   = 1'b1;
            w_en_alu = 1'b1;
            w_rw     = 1'b1;
            w_ns     = S_EX1;
          end
          OP_CBZ, OP_CBNZ: begin
            w_sa = w_rd;
            w_sb = 5'd31;
            w_fs = FS_OR;
            if ((w_op == OP_CBZ) ? status[4] : ~status[4]) w_ps = 2'b10;
          end
          OP_BCOND: begin
            if (f_cond_holds(instruction[3:0], status[3:0])) w_ps = 2'b10;
          end
          OP_B: w_ps = 2'b10;
          OP_BL: begin
            w_ps     = 2'b10;
            w_da     = 5'd30;
            w_pcsel  = 1'b1;
            w_sb     = 5'd31;
            w_fs     = FS_OR;
            w_en_alu = 1'b1;
            w_rw     = 1'b1;
          end
          OP_BR: w_ps = 2'b11;
          default: ;
        endcase
      end
      S_EX1: begin
        if (w_op == OP_MOVK) begin
          w_da     = w_rd;
          w_sa     = w_rd;
          w_sb     = w_rm;
          w_fs     = FS_OR;
          w_bsel   = 1'b1;
          w_en_alu = 1'b1;
          w_rw     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_next = state_t'(w_ns);

  assign w_cw = {w_da, w_sa, w_sb, w_fs, w_c0, w_rw, w_mw, w_bsel,
                 w_en_alu, w_en_mem, w_en_pc, w_ps, w_pcsel, w_sl, w_irload, w_ns};

  always_comb begin
    w_const = '0;
    case (w_op)
      OP_ADDI, OP_SUBI, OP_ADDIS, OP_SUBIS,
      OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS: w_const = {52'd0, instruction[21:10]};
      OP_LDUR, OP_STUR:                    w_const = {{55{instruction[20]}}, instruction[20:12]};
      OP_MOVZ, OP_MOVK:                    w_const = {48'd0, instruction[20:5]} << {instruction[22:21], 4'b0000};
      OP_CBZ, OP_CBNZ, OP_BCOND:           w_const = {{45{instruction[23]}}, instruction[23:5]};
      OP_B, OP_BL:                         w_const = {{38{instruction[25]}}, instruction[25:0]};
      OP_LSL, OP_LSR:                      w_const = {58'd0, instruction[15:10]};
      default:                             w_const = '0;
    endcase
  end

  assign ControlWord = reset ? w_cw : '0;
  assign constant    = reset ? w_const : '0;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Bench for legv8_control_unit: directed test-plan cases plus a randomized
// instruction stream checked against a mnemonic-level reference model.
module tb_legv8_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = '0;
  logic [4:0]  status = '0;
  logic [33:0] ControlWord;
  logic [63:0] constant;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int phase     = 0;

  legv8_control_unit dut (
    .clock(clock),
    .reset(reset),
    .ControlWord(ControlWord),
    .constant(constant),
    .instruction(instruction),
    .status(status)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", total_cnt);
    $fatal(1);
  end

  function automatic string mnem(input logic [31:0] ins);
    logic [10:0] op;
    op = ins[31:21];
    if (op == 11'b10001011000) return "ADD";
    if (op == 11'b11001011000) return "SUB";
    if (op == 11'b10101011000) return "ADDS";
    if (op == 11'b11101011000) return "SUBS";
    if (op ==? 11'b1001000100?) return "ADDI";
    if (op ==? 11'b1101000100?) return "SUBI";
    if (op ==? 11'b1011000100?) return "ADDIS";
    if (op ==? 11'b1111000100?) return "SUBIS";
    if (op == 11'b10001010000) return "AND";
    if (op == 11'b10101010000) return "ORR";
    if (op == 11'b11001010000) return "EOR";
    if (op == 11'b11101010000) return "ANDS";
    if (op ==? 11'b1001001000?) return "ANDI";
    if (op ==? 11'b1011001000?) return "ORRI";
    if (op ==? 11'b1101001000?) return "EORI";
    if (op ==? 11'b1111001000?) return "ANDIS";
    if (op == 11'b11010011011) return "LSL";
    if (op == 11'b11010011010) return "LSR";
    if (op == 11'b11111000010) return "LDUR";
    if (op == 11'b11111000000) return "STUR";
    if (op ==? 11'b110100101??) return "MOVZ";
    if (op ==? 11'b111100101??) return "MOVK";
    if (op ==? 11'b10110100???) return "CBZ";
    if (op ==? 11'b10110101???) return "CBNZ";
    if (op ==? 11'b01010100???) return "BCOND";
    if (op ==? 11'b000101?????) return "B";
    if (op ==? 11'b100101?????) return "BL";
    if (op == 11'b11010110000) return "BR";
    return "NOP";
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] st);
    bit z, n, cy, v;
    z = st[0]; n = st[1]; cy = st[2]; v = st[3];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] model_const(input logic [31:0] ins);
    string m;
    m = mnem(ins);
    if (m == "ADDI" || m == "SUBI" || m == "ADDIS" || m == "SUBIS" ||
        m == "ANDI" || m == "ORRI" || m == "EORI" || m == "ANDIS") return 64'(ins[21:10]);
    if (m == "LDUR" || m == "STUR") return 64'($signed(ins[20:12]));
    if (m == "MOVZ" || m == "MOVK") return 64'(ins[20:5]) << (16 * ins[22:21]);
    if (m == "CBZ" || m == "CBNZ" || m == "BCOND") return 64'($signed(ins[23:5]));
    if (m == "B" || m == "BL") return 64'($signed(ins[25:0]));
    if (m == "LSL" || m == "LSR") return 64'(ins[15:10]);
    return 64'd0;
  endfunction

  function automatic logic [33:0] model_cw(input int ph, input logic [31:0] ins, input logic [4:0] st);
    string m;
    logic [4:0] da, sa, sb, fs;
    logic c0, rw, mw, bs, ea, em, ep, pcs, sl, irl;
    logic [1:0] ps, ns;
    m = mnem(ins);
    da = 0; sa = 0; sb = 0; fs = 0; c0 = 0; rw = 0; mw = 0; bs = 0;
    ea = 0; em = 0; ep = 0; pcs = 0; sl = 0; irl = 0; ps = 0; ns = 0;
    if (ph == 0) begin
      irl = 1; ps = 2'b01; ns = 2'b01;
    end else if (m != "NOP") begin
      da = ins[4:0]; sa = ins[9:5]; sb = ins[20:16];
      if (ph == 2) begin
        sa = ins[4:0]; fs = 5'b00100; bs = 1; ea = 1; rw = 1;
      end else if (m == "ADD" || m == "SUB" || m == "ADDS" || m == "SUBS" ||
                   m == "ADDI" || m == "SUBI" || m == "ADDIS" || m == "SUBIS") begin
        fs = 5'b01000; ea = 1; rw = 1;
        if (m == "SUB" || m == "SUBS" || m == "SUBI" || m == "SUBIS") begin fs = 5'b01010; c0 = 1; end
        sl = (m == "ADDS" || m == "SUBS" || m == "ADDIS" || m == "SUBIS");
        bs = (m == "ADDI" || m == "SUBI" || m == "ADDIS" || m == "SUBIS");
      end else if (m == "AND" || m == "ORR" || m == "EOR" || m == "ANDS" ||
                   m == "ANDI" || m == "ORRI" || m == "EORI" || m == "ANDIS") begin
        fs = (m == "ORR" || m == "ORRI") ? 5'b00100 : (m == "EOR" || m == "EORI") ? 5'b01100 : 5'b00000;
        ea = 1; rw = 1;
        sl = (m == "ANDS" || m == "ANDIS");
        bs = (m == "ANDI" || m == "ORRI" || m == "EORI" || m == "ANDIS");
      end else if (m == "LSL" || m == "LSR") begin
        fs = (m == "LSL") ? 5'b10000 : 5'b10100; bs = 1; ea = 1; rw = 1;
      end else if (m == "LDUR") begin
        fs = 5'b01000; bs = 1; em = 1; rw = 1;
      end else if (m == "STUR") begin
        fs = 5'b01000; bs = 1; mw = 1; sb = ins[4:0];
      end else if (m == "MOVZ") begin
        sa = 31; fs = 5'b00100; bs = 1; ea = 1; rw = 1;
      end else if (m == "MOVK") begin
        sa = ins[4:0]; fs = 5'b00010; bs = 1; ea = 1; rw = 1; ns = 2'b10;
      end else if (m == "CBZ" || m == "CBNZ") begin
        sa = ins[4:0]; sb = 31; fs = 5'b00100;
        if ((m == "CBZ") == st[4]) ps = 2'b10;
      end else if (m == "BCOND") begin
        if (cond_ok(ins[3:0], st)) ps = 2'b10;
      end else if (m == "B") begin
        ps = 2'b10;
      end else if (m == "BL") begin
        ps = 2'b10; da = 30; pcs = 1; sb = 31; fs = 5'b00100; ea = 1; rw = 1;
      end else if (m == "BR") begin
        ps = 2'b11;
      end
    end
    return {da, sa, sb, fs, c0, rw, mw, bs, ea, em, ep, ps, pcs, sl, irl, ns};
  endfunction

  function automatic int next_phase(input int ph, input logic [31:0] ins);
    if (ph == 0) return 1;
    if (ph == 1 && mnem(ins) == "MOVK") return 2;
    return 0;
  endfunction

  function automatic logic [31:0] rand_ins(input int k);
    logic [10:0] val;
    int len;
    logic [31:0] r, mask;
    r = $urandom;
    case (k)
      0:  begin val = 11'b10001011000; len = 11; end
      1:  begin val = 11'b11001011000; len = 11; end
      2:  begin val = 11'b10101011000; len = 11; end
      3:  begin val = 11'b11101011000; len = 11; end
      4:  begin val = 11'b1001000100;  len = 10; end
      5:  begin val = 11'b1101000100;  len = 10; end
      6:  begin val = 11'b1011000100;  len = 10; end
      7:  begin val = 11'b1111000100;  len = 10; end
      8:  begin val = 11'b10001010000; len = 11; end
      9:  begin val = 11'b10101010000; len = 11; end
      10: begin val = 11'b11001010000; len = 11; end
      11: begin val = 11'b11101010000; len = 11; end
      12: begin val = 11'b1001001000;  len = 10; end
      13: begin val = 11'b1011001000;  len = 10; end
      14: begin val = 11'b1101001000;  len = 10; end
      15: begin val = 11'b1111001000;  len = 10; end
      16: begin val = 11'b11010011011; len = 11; end
      17: begin val = 11'b11010011010; len = 11; end
      18: begin val = 11'b11111000010; len = 11; end
      19: begin val = 11'b11111000000; len = 11; end
      20: begin val = 11'b110100101;   len = 9;  end
      21: begin val = 11'b111100101;   len = 9;  end
      22: begin val = 11'b10110100;    len = 8;  end
      23: begin val = 11'b10110101;    len = 8;  end
      24: begin val = 11'b01010100;    len = 8;  end
      25: begin val = 11'b000101;      len = 6;  end
      26: begin val = 11'b100101;      len = 6;  end
      27: begin val = 11'b11010110000; len = 11; end
      default: return r;
    endcase
    mask = 32'hFFFF_FFFF << (32 - len);
    return (r & ~mask) | (32'(val) << (32 - len));
  endfunction

  task automatic tick();
    phase = next_phase(phase, instruction);
    @(posedge clock);
    #1;
  endtask

  task automatic to_fetch();
    for (int i = 0; i < 3 && phase != 0; i++) tick();
  endtask

  task automatic test_reset();
    instruction = 32'h9120_0000;
    status = 5'b11111;
    #2;
    total_cnt++;
    if (ControlWord !== 34'h0) $display("FAIL reset_cw: got %h expected %h", ControlWord, 34'h0);
    else pass_cnt++;
    total_cnt++;
    if (constant !== 64'h0) $display("FAIL reset_const: got %h expected %h", constant, 64'h0);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
    phase = 0;
    #1;
    total_cnt++;
    if (ControlWord !== 34'h25) $display("FAIL fetch_cw: got %h expected %h", ControlWord, 34'h25);
    else pass_cnt++;
    total_cnt++;
    if (constant !== 64'h800) $display("FAIL fetch_const: got %h expected %h", constant, 64'h800);
    else pass_cnt++;
  endtask

  task automatic test_alu();
    to_fetch();
    instruction = 32'h9120_0000;
    status = 5'b0;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h21600) $display("FAIL addi_cw: got %h expected %h", ControlWord, 34'h21600);
    else pass_cnt++;
    total_cnt++;
    if (constant !== 64'h800) $display("FAIL addi_const: got %h expected %h", constant, 64'h800);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h25) $display("FAIL addi_next_fetch: got %h expected %h", ControlWord, 34'h25);
    else pass_cnt++;
    instruction = 32'hAB00_0000;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h21208) $display("FAIL adds_cw: got %h expected %h", ControlWord, 34'h21208);
    else pass_cnt++;
    total_cnt++;
    if (constant !== 64'h0) $display("FAIL adds_const: got %h expected %h", constant, 64'h0);
    else pass_cnt++;
    to_fetch();
    instruction = 32'hEB00_0000;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h2B208) $display("FAIL subs_cw: got %h expected %h", ControlWord, 34'h2B208);
    else pass_cnt++;
    to_fetch();
    instruction = 32'h0000_0000;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h0) $display("FAIL nop_cw: got %h expected %h", ControlWord, 34'h0);
    else pass_cnt++;
  endtask

  task automatic test_mem();
    to_fetch();
    instruction = 32'hF840_0000;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h21500) $display("FAIL ldur_cw: got %h expected %h", ControlWord, 34'h21500);
    else pass_cnt++;
    to_fetch();
    instruction = 32'hF800_0000;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h20C00) $display("FAIL stur_cw: got %h expected %h", ControlWord, 34'h20C00);
    else pass_cnt++;
  endtask

  task automatic test_movk();
    to_fetch();
    instruction = 32'hF2A0_0020;
    #1;
    total_cnt++;
    if (constant !== 64'h10000) $display("FAIL movk_const: got %h expected %h", constant, 64'h10000);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h9602) $display("FAIL movk_ex0: got %h expected %h", ControlWord, 34'h9602);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h11600) $display("FAIL movk_ex1: got %h expected %h", ControlWord, 34'h11600);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h25) $display("FAIL movk_back_to_fetch: got %h expected %h", ControlWord, 34'h25);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    #1;
    total_cnt++;
    if (ControlWord !== 34'h0) $display("FAIL midreset_cw: got %h expected %h", ControlWord, 34'h0);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
    phase = 0;
    #1;
    total_cnt++;
    if (ControlWord !== 34'h25) $display("FAIL midreset_fetch: got %h expected %h", ControlWord, 34'h25);
    else pass_cnt++;
  endtask

  task automatic test_branch();
    to_fetch();
    instruction = 32'h5400_0000;
    status = 5'b00001;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h40) $display("FAIL beq_taken: got %h expected %h", ControlWord, 34'h40);
    else pass_cnt++;
    status = 5'b00000;
    #1;
    total_cnt++;
    if (ControlWord !== 34'h0) $display("FAIL beq_not_taken: got %h expected %h", ControlWord, 34'h0);
    else pass_cnt++;
    to_fetch();
    instruction = 32'h9400_0001;
    tick();
    total_cnt++;
    if (ControlWord !== 34'h3C0F91250) $display("FAIL bl_cw: got %h expected %h", ControlWord, 34'h3C0F91250);
    else pass_cnt++;
    total_cnt++;
    if (constant !== 64'h1) $display("FAIL bl_const: got %h expected %h", constant, 64'h1);
    else pass_cnt++;
  endtask

  task automatic test_random_stream();
    logic [33:0] exp_cw;
    logic [63:0] exp_k;
    to_fetch();
    for (int n = 0; n < 250; n++) begin
      instruction = rand_ins($urandom_range(0, 29));
      for (int c = 0; c < 4; c++) begin
        status = 5'($urandom);
        #1;
        exp_cw = model_cw(phase, instruction, status);
        exp_k  = model_const(instruction);
        total_cnt++;
        if (ControlWord !== exp_cw)
          $display("FAIL rand_cw ins=%h st=%b phase=%0d: got %h expected %h", instruction, status, phase, ControlWord, exp_cw);
        else pass_cnt++;
        total_cnt++;
        if (constant !== exp_k)
          $display("FAIL rand_const ins=%h: got %h expected %h", instruction, constant, exp_k);
        else pass_cnt++;
        status = 5'($urandom);
        #1;
        exp_cw = model_cw(phase, instruction, status);
        total_cnt++;
        if (ControlWord !== exp_cw)
          $display("FAIL rand_cw_status ins=%h st=%b phase=%0d: got %h expected %h", instruction, status, phase, ControlWord, exp_cw);
        else pass_cnt++;
        tick();
        if (phase == 0) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_movk();
    test_branch();
    test_random_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multi-cycle control unit for the LEGv8 (ARMv8 subset) datapath.
- Decodes the instruction currently presented on `instruction` and steps a small state machine: FETCH, then one or two execute cycles.
- Each cycle it emits a 34-bit control word that drives the register file, ALU, data memory, PC and status register.
- It also emits a 64-bit extended immediate `constant` for the datapath B-input and the branch adder.

Parameters:
- none

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- ControlWord  output  34  datapath control word, layout below
- constant  output  64  extended immediate
- instruction  input  32  current instruction (IR contents)
- status  input  5  status[0]=Z, [1]=N, [2]=C, [3]=V (registered flags); [4]=zero-detect of the current ALU result

Behaviour:
- ControlWord layout:
  - [33:29] DA (destination register)
  - [28:24] SA
  - [23:19] SB
  - [18:14] FS: FS[4:2] op (000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR); FS[1] invert B; FS[0] invert A
  - [13] C0 (ALU carry-in)
  - [12] RegWrite
  - [11] MemWrite
  - [10] Bsel (1 = constant, 0 = register B)
  - [9] EN_ALU, [8] EN_MEM, [7] EN_PC (data-bus drivers)
  - [6:5] PS: 00 hold, 01 PC+4, 10 PC + (constant<<2), 11 PC <- A bus
  - [4] PCsel (A input = PC)
  - [3] SL (status load)
  - [2] IRload
  - [1:0] NS (next state)
- States: 00 FETCH, 01 EX0, 10 EX1. The state register loads NS on every rising clock edge.
- Reset (low): state forced to FETCH immediately. ControlWord = 0 and constant = 0 while reset is low.
- FETCH word: IRload=1, PS=01, NS=01; every other field 0.
- EX0 word, by opcode `instruction[31:21]` (x = don't care); unless noted, NS=00:
  - Field mapping: Rd=[4:0], Rn=[9:5], Rm=[20:16]. Default DA=Rd, SA=Rn, SB=Rm.
  - ADD 10001011000, SUB 11001011000, ADDS 10101011000, SUBS 11101011000: FS=ADD, EN_ALU, RegWrite. SUB forms set FS[1]=1 and C0=1. S forms set SL=1.
  - ADDI/SUBI/ADDIS/SUBIS (1001000100x, 1101000100x, 1011000100x, 1111000100x): same as the register forms, with Bsel=1.
  - AND 10001010000, ORR 10101010000, EOR 11001010000, ANDS 11101010000: logic op, EN_ALU, RegWrite; ANDS sets SL.
  - ANDI/ORRI/EORI/ANDIS (1001001000x, 1011001000x, 1101001000x, 1111001000x): same as the register forms, with Bsel=1.
  - LSL 11010011011, LSR 11010011010: shift op, Bsel=1, EN_ALU, RegWrite.
  - LDUR 11111000010: FS=ADD, Bsel=1, EN_MEM, RegWrite, DA=Rt.
  - STUR 11111000000: FS=ADD, Bsel=1, MemWrite, SB=Rt, RegWrite=0.
  - MOVZ 110100101xx: SA=31, FS=OR, Bsel=1, EN_ALU, RegWrite.
  - MOVK 111100101xx: EX0 does SA=Rd, FS=AND with FS[1]=1, Bsel=1, EN_ALU, RegWrite, NS=10. EX1 does SA=Rd, FS=OR, Bsel=1, EN_ALU, RegWrite, NS=00.
  - CBZ 10110100xxx, CBNZ 10110101xxx: SA=Rt, SB=31, FS=OR, no writes. PS=10 if status[4] (CBZ) or !status[4] (CBNZ); else PS=00.
  - B.cond 01010100xxx: PS=10 if cond [3:0] holds, else 00.
    - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V.
    - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE its inverse; 1110/1111 always.
  - B 000101xxxxx: PS=10.
  - BL 100101xxxxx: PS=10, DA=30, PCsel=1, SB=31, FS=OR, EN_ALU, RegWrite (link = PC already incremented).
  - BR 11010110000: SA=Rn, PS=11.
  - Unrecognised opcode: all enables 0, PS=00, NS=00 (NOP).
- constant, combinational from `instruction` (0 for R-format arithmetic/logic and BR):
  - I-format: zero-extended [21:10].
  - D-format: sign-extended [20:12].
  - MOVZ/MOVK: zero-extended [20:5] << (16*[22:21]).
  - CB/B.cond: sign-extended [23:5].
  - B/BL: sign-extended [25:0].
  - LSL/LSR: zero-extended shamt [15:10].
- ControlWord is a combinational function of state, instruction and status. A branch decision tracks status within the same cycle.
- A reset asserted mid-instruction aborts it; the first word after reset release is FETCH.

Test Plan:
- Reset low -> ControlWord=0, constant=0. Release -> FETCH word: IRload=1, PS=01, NS=01.
- ADDI 0x91200000 -> EX0: constant=0x800, FS=ADD, Bsel=1, RegWrite=1, SL=0, NS=00.
- ADDS 0xAB000000 -> EX0: SL=1, Bsel=0, FS=ADD. SUBS -> additionally FS[1]=1, C0=1.
- LDUR 0xF8400000 -> EN_MEM=1, RegWrite=1, MemWrite=0. STUR 0xF8000000 -> MemWrite=1, RegWrite=0.
- MOVK 0xF2A00020 (hw=1, imm16=1) -> constant=0x10000. Sequence FETCH, EX0 (AND, FS[1]=1, NS=10), EX1 (OR, NS=00): three cycles.
- B.cond EQ 0x54000000 -> with status[0]=1 PS=10, with status[0]=0 PS=00. BL 0x94000001 -> constant=1, DA=30, PS=10, RegWrite=1.
